soil_moisture_monitor: RTL

Multi-channel soil-moisture front end. It drives a serial ADC and an external analog channel mux, and averages 2^AVG_LOG2 conversions per channel. Each average is converted to a calibrated 0–100 % moisture value by linear interpolation. Results stream out one channel at a time with a valid strobe, for the downstream irrigation controller and logger.

---
 rtl/soil_pkg.sv | 17 +
 rtl/soil_seq_divider.sv | 77 +++++++
 rtl/soil_moisture_monitor.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/soil_pkg.sv
// rtl/soil_pkg.sv - shared types and constants for the soil-moisture front end
package soil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SHIFT,
        ST_ACCUM,
        ST_MAP,
        ST_DIVIDE,
        ST_OUTPUT
    } soil_state_e;

    localparam int PCT_MAX   = 100;
    localparam int PCT_SCALE = 100;

endpackage

// File: rtl/soil_seq_divider.sv
// rtl/soil_seq_divider.sv - restoring unsigned divider, one quotient bit per clk
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              load dividend/divisor; first quotient bit is resolved in this cycle
//   dividend, divisor  W-bit unsigned operands
//   done               high for one cycle, W cycles after start, while quotient is valid
//   quotient           W-bit quotient (held until the next start)
module soil_seq_divider #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient
);
    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     quo_q, quo_d, rem_q, rem_d, den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [W-1:0] rem_in, quo_in, den_in;
    logic [W:0]   rem_sh, diff;
    logic         fits;

    always_comb begin
        // The start cycle already performs the first step, so exactly W
        // cycles separate start from done.
        rem_in = start ? '0       : rem_q;
        quo_in = start ? dividend : quo_q;
        den_in = start ? divisor  : den_q;
        rem_sh = {rem_in, quo_in[W-1]};
        diff   = rem_sh - {1'b0, den_in};
        fits   = (rem_sh >= {1'b0, den_in});

        rem_d  = rem_q;
        quo_d  = quo_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start || (busy_q && cnt_q != '0)) begin
            rem_d = fits ? W'(diff) : W'(rem_sh);
            quo_d = {quo_in[W-2:0], fits};
            den_d = den_in;
            cnt_d = start ? CNT_W'(W - 1) : cnt_q - CNT_W'(1);
        end
        if (start) begin
            busy_d = 1'b1;
        end else if (busy_q && cnt_q == '0) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done     = busy_q && (cnt_q == '0);
    assign quotient = quo_q;

endmodule

// File: rtl/soil_moisture_monitor.sv
// rtl/soil_moisture_monitor.sv - multi-channel soil-moisture ADC scanner with calibrated percent output
//
// Optional feature macro: SOIL_ALARM_EN (adds alarm_thresh input and per-channel alarm output).
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   start                   one-cycle scan request, ignored while busy
//   cal_dry, cal_wet        calibration raw readings, captured on accepted start
//   adc_sdo                 ADC serial data in (MSB first)
//   adc_cs_n, adc_sclk      ADC chip select (active low) and serial clock (idles low)
//   adc_ch                  analog mux select
//   busy                    scan in progress
//   out_valid, out_ch       one-cycle result strobe and its channel
//   moisture_pct, out_err   0..100 result and invalid-calibration flag, held between strobes
//   alarm_thresh, alarm     dry-alarm threshold and per-channel alarm (SOIL_ALARM_EN only)
module soil_moisture_monitor
    import soil_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int ADC_BITS = 10,
    parameter int AVG_LOG2 = 2,
    parameter int SCLK_DIV = 4,
    parameter int HYST     = 5,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADC_BITS-1:0] cal_dry,
    input  logic [ADC_BITS-1:0] cal_wet,
    input  logic                adc_sdo,
    output logic                adc_cs_n,
    output logic                adc_sclk,
    output logic [CH_W-1:0]     adc_ch,
    output logic                busy,
    output logic                out_valid,
    output logic [CH_W-1:0]     out_ch,
    output logic [7:0]          moisture_pct,
`ifdef SOIL_ALARM_EN
    input  logic [7:0]          alarm_thresh,
    output logic [NUM_CH-1:0]   alarm,
`endif
    output logic                out_err
);
    localparam int DIV_W  = ADC_BITS + 7;
    localparam int ACC_W  = ADC_BITS + AVG_LOG2;
    localparam int DCNT_W = $clog2(SCLK_DIV);
    localparam int BCNT_W = $clog2(ADC_BITS) + 1;
    localparam int SMP_W  = AVG_LOG2 + 1;

    soil_state_e         state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [SMP_W-1:0]    smp_q, smp_d;
    logic                sclk_q, sclk_d;
    logic [ADC_BITS-1:0] sh_q, sh_d, dry_q, dry_d, wet_q, wet_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [7:0]          pct_q, pct_d;
    logic                err_q, err_d;

    logic [ADC_BITS-1:0] avg;
    logic [DIV_W-1:0]    div_num, div_den, div_quo;
    logic                div_start, div_done;

    assign avg     = ADC_BITS'(acc_q >> AVG_LOG2);
    assign div_num = DIV_W'(DIV_W'(dry_q - avg) * DIV_W'(PCT_SCALE));
    assign div_den = DIV_W'(dry_q - wet_q);

    soil_seq_divider #(.W(DIV_W)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_num),
        .divisor  (div_den),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        dcnt_d    = dcnt_q;
        bcnt_d    = bcnt_q;
        smp_d     = smp_q;
        sclk_d    = sclk_q;
        sh_d      = sh_q;
        acc_d     = acc_q;
        dry_d     = dry_q;
        wet_d     = wet_q;
        pct_d     = pct_q;
        err_d     = err_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dry_d   = cal_dry;
                    wet_d   = cal_wet;
                    ch_d    = '0;
                    acc_d   = '0;
                    smp_d   = '0;
                    dcnt_d  = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (dcnt_q == DCNT_W'(SCLK_DIV - 1)) begin
                    dcnt_d  = '0;
                    bcnt_d  = '0;
                    state_d = ST_SHIFT;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            ST_SHIFT: begin
                if (dcnt_q == DCNT_W'(SCLK_DIV - 1)) begin
                    dcnt_d = '0;
                    sclk_d = !sclk_q;
                    if (!sclk_q) begin
                        sh_d = {sh_q[ADC_BITS-2:0], adc_sdo};
                    end else if (bcnt_q == BCNT_W'(ADC_BITS - 1)) begin
                        state_d = ST_ACCUM;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + ACC_W'(sh_q);
                if (smp_q == SMP_W'((1 << AVG_LOG2) - 1)) begin
                    state_d = ST_MAP;
                end else begin
                    smp_d   = smp_q + SMP_W'(1);
                    state_d = ST_SETTLE;
                end
            end
            ST_MAP: begin
                // Result registers only change on entry to OUTPUT so the
                // previous result stays visible until the next strobe.
                if (dry_q <= wet_q) begin
                    pct_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_OUTPUT;
                end else if (avg >= dry_q) begin
                    pct_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_OUTPUT;
                end else if (avg <= wet_q) begin
                    pct_d   = 8'(PCT_MAX);
                    err_d   = 1'b0;
                    state_d = ST_OUTPUT;
                end else begin
                    div_start = 1'b1;
                    state_d   = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    // Strictly inside (wet, dry) the quotient is below 100.
                    pct_d   = 8'(div_quo);
                    err_d   = 1'b0;
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    acc_d   = '0;
                    smp_d   = '0;
                    dcnt_d  = '0;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            dcnt_q  <= '0;
            bcnt_q  <= '0;
            smp_q   <= '0;
            sclk_q  <= 1'b0;
            sh_q    <= '0;
            acc_q   <= '0;
            dry_q   <= '0;
            wet_q   <= '0;
            pct_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            dcnt_q  <= dcnt_d;
            bcnt_q  <= bcnt_d;
            smp_q   <= smp_d;
            sclk_q  <= sclk_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            dry_q   <= dry_d;
            wet_q   <= wet_d;
            pct_q   <= pct_d;
            err_q   <= err_d;
        end
    end

`ifdef SOIL_ALARM_EN
    logic [NUM_CH-1:0] alarm_q, alarm_d;
    logic [8:0]        clr_lvl;

    always_comb begin
        alarm_d = alarm_q;
        clr_lvl = {1'b0, alarm_thresh} + 9'(HYST);
        if (state_q == ST_OUTPUT && !err_q) begin
            if (pct_q < alarm_thresh) begin
                alarm_d[ch_q] = 1'b1;
            end else if ({1'b0, pct_q} >= clr_lvl) begin
                alarm_d[ch_q] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_q <= '0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`endif

    assign adc_cs_n     = (state_q != ST_SHIFT);
    assign adc_sclk     = sclk_q;
    assign adc_ch       = ch_q;
    assign busy         = (state_q != ST_IDLE);
    assign out_valid    = (state_q == ST_OUTPUT);
    assign out_ch       = ch_q;
    assign moisture_pct = pct_q;
    assign out_err      = err_q;

endmodule
